// File: rtl/store_buffer_datapath_if.sv
// -----------------------------------------------------------------------------
// store_buffer_datapath_if
//   Bundles every non-clock signal of the store buffer.
//   slave  : the store buffer itself
//   master : the environment (store controller / LSU / dcache side)
//
//   Push side   : stb_wr_en, lsummu2stb_addr/wdata/sel_byte -> stb_full/empty/count
//   Drain side  : stb2dcache_req/w_en/addr/wdata/sel_byte   <- dcache2stb_ack
//   Load lookup : lsummu2stb_ld_req/ld_addr                 -> stb2lsummu_ld_hit
// -----------------------------------------------------------------------------
interface store_buffer_datapath_if #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int SEL_W = DATA_W / 8;

  // push from the store-buffer controller
  logic              stb_wr_en;
  logic [ADDR_W-1:0] lsummu2stb_addr;
  logic [DATA_W-1:0] lsummu2stb_wdata;
  logic [SEL_W-1:0]  lsummu2stb_sel_byte;
  logic              stb_full;
  logic              stb_empty;
  logic [CNT_W-1:0]  stb_count;

  // drain to the dcache
  logic              stb2dcache_req;
  logic              stb2dcache_w_en;
  logic [ADDR_W-1:0] stb2dcache_addr;
  logic [DATA_W-1:0] stb2dcache_wdata;
  logic [SEL_W-1:0]  stb2dcache_sel_byte;
  logic              dcache2stb_ack;

  // load hazard lookup
  logic              lsummu2stb_ld_req;
  logic [ADDR_W-1:0] lsummu2stb_ld_addr;
  logic              stb2lsummu_ld_hit;

  modport slave (
    input  stb_wr_en, lsummu2stb_addr, lsummu2stb_wdata, lsummu2stb_sel_byte,
    input  dcache2stb_ack, lsummu2stb_ld_req, lsummu2stb_ld_addr,
    output stb_full, stb_empty, stb_count,
    output stb2dcache_req, stb2dcache_w_en, stb2dcache_addr,
    output stb2dcache_wdata, stb2dcache_sel_byte, stb2lsummu_ld_hit
  );

  modport master (
    output stb_wr_en, lsummu2stb_addr, lsummu2stb_wdata, lsummu2stb_sel_byte,
    output dcache2stb_ack, lsummu2stb_ld_req, lsummu2stb_ld_addr,
    input  stb_full, stb_empty, stb_count,
    input  stb2dcache_req, stb2dcache_w_en, stb2dcache_addr,
    input  stb2dcache_wdata, stb2dcache_sel_byte, stb2lsummu_ld_hit
  );
endinterface

// File: rtl/store_buffer_datapath.sv
// -----------------------------------------------------------------------------
// store_buffer_datapath
//   Circular FIFO of committed stores sitting between the LSU/MMU write path
//   and the data cache. Entries drain strictly in order over a req/ack
//   handshake; loads are checked against every occupied entry (word
//   granularity) so the LSU can stall on a hazard. No data forwarding.
//
// Ports
//   clk  : clock
//   rst  : synchronous, active-high reset
//   bus  : store_buffer_datapath_if.slave (push, drain and load-lookup groups)
//
// DEPTH must be a power of two, at least 2.
// -----------------------------------------------------------------------------
module store_buffer_datapath #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  store_buffer_datapath_if.slave        bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;     // extra MSB is the wrap bit
  localparam int SEL_W = DATA_W / 8;

  typedef enum logic {
    D_IDLE,
    D_REQ
  } drain_state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] addr_mem_q [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [SEL_W-1:0]  sel_mem_q  [DEPTH];
  logic [DEPTH-1:0]  valid_q,  valid_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;

  drain_state_e      state_q,  state_d;
  logic              req_q,    req_d;
  logic [ADDR_W-1:0] out_addr_q,  out_addr_d;
  logic [DATA_W-1:0] out_wdata_q, out_wdata_d;
  logic [SEL_W-1:0]  out_sel_q,   out_sel_d;

  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              ld_match;

  assign wr_idx = wr_ptr_q[IDX_W-1:0];
  assign rd_idx = rd_ptr_q[IDX_W-1:0];

  // Same index with opposite wrap bits means the writer lapped the reader.
  assign full  = (wr_idx == rd_idx) && (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  // Both qualifiers use registered state only: a pop in this cycle never
  // frees room for a push in the same cycle.
  assign push = bus.stb_wr_en && !full;
  assign pop  = (state_q == D_REQ) && bus.dcache2stb_ack;

  // ---------------------------------------------------------------------------
  // Pointer / valid-bit next state
  // ---------------------------------------------------------------------------
  // NOTE: every variable driven from always_comb gets a default on entry;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    valid_d  = valid_q;
    // Clear before set; push and pop never target the same slot because a
    // push needs !full and a pop needs an occupied head.
    if (pop) begin
      valid_d[rd_idx] = 1'b0;
      rd_ptr_d        = rd_ptr_q + PTR_W'(1);
    end
    if (push) begin
      valid_d[wr_idx] = 1'b1;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Drain FSM: D_IDLE latches the head into the output registers, D_REQ holds
  // them stable until the dcache acks. Two cycles minimum per entry.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    out_addr_d  = out_addr_q;
    out_wdata_d = out_wdata_q;
    out_sel_d   = out_sel_q;
    unique case (state_q)
      D_IDLE: begin
        if (!empty) begin
          out_addr_d  = addr_mem_q[rd_idx];
          out_wdata_d = data_mem_q[rd_idx];
          out_sel_d   = sel_mem_q[rd_idx];
          req_d       = 1'b1;
          state_d     = D_REQ;
        end
      end
      D_REQ: begin
        if (bus.dcache2stb_ack) begin
          req_d   = 1'b0;
          state_d = D_IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = D_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control registers (reset)
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      valid_q     <= '0;
      state_q     <= D_IDLE;
      req_q       <= 1'b0;
      out_addr_q  <= '0;
      out_wdata_q <= '0;
      out_sel_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      valid_q     <= valid_d;
      state_q     <= state_d;
      req_q       <= req_d;
      out_addr_q  <= out_addr_d;
      out_wdata_q <= out_wdata_d;
      out_sel_q   <= out_sel_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Entry payload storage
  // ---------------------------------------------------------------------------
  // NOTE: the payload arrays carry no reset; the valid bits and pointers
  // decide which contents mean anything, so stale data is never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem_q[wr_idx] <= bus.lsummu2stb_addr;
      data_mem_q[wr_idx] <= bus.lsummu2stb_wdata;
      sel_mem_q[wr_idx]  <= bus.lsummu2stb_sel_byte;
    end
  end

  // ---------------------------------------------------------------------------
  // Load hazard: word-address compare against every occupied entry, including
  // the one currently being drained. Byte enables are deliberately ignored.
  // ---------------------------------------------------------------------------
  always_comb begin
    ld_match = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] &&
          (addr_mem_q[i][ADDR_W-1:2] == bus.lsummu2stb_ld_addr[ADDR_W-1:2])) begin
        ld_match = 1'b1;
      end
    end
  end

  // Byte-offset bits take no part in the word compare.
  logic ld_addr_offset_unused;
  assign ld_addr_offset_unused = ^bus.lsummu2stb_ld_addr[1:0];

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.stb_full            = full;
  assign bus.stb_empty           = empty;
  assign bus.stb_count           = wr_ptr_q - rd_ptr_q;
  assign bus.stb2dcache_req      = req_q;
  assign bus.stb2dcache_w_en     = req_q;
  assign bus.stb2dcache_addr     = out_addr_q;
  assign bus.stb2dcache_wdata    = out_wdata_q;
  assign bus.stb2dcache_sel_byte = out_sel_q;
  assign bus.stb2lsummu_ld_hit   = bus.lsummu2stb_ld_req && ld_match;

endmodule
